// File: rtl/wishbone_arbitrated_interconnect.sv
// Single-master Wishbone interconnect: address-decoded slave select, one transaction
// at a time, registered ack/error/read-data back to the master and ack timeout.
module wishbone_arbitrated_interconnect #(
    parameter int NUM_SLAVES = 4,
    parameter int SEL_MSB    = 31,
    parameter int SEL_LSB    = 24,
    parameter int TIMEOUT    = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     m_we_i,
    input  logic                     m_cyc_i,
    input  logic                     m_stb_i,
    input  logic [31:0]              m_adr_i,
    input  logic [31:0]              m_dat_i,
    output logic [31:0]              m_dat_o,
    output logic                     m_ack_o,
    output logic                     m_err_o,
    output logic                     m_int_o,
    output logic [NUM_SLAVES-1:0]    s_we_o,
    output logic [NUM_SLAVES-1:0]    s_cyc_o,
    output logic [NUM_SLAVES-1:0]    s_stb_o,
    output logic [31:0]              s_adr_o,
    output logic [31:0]              s_dat_o,
    input  logic [32*NUM_SLAVES-1:0] s_dat_i,
    input  logic [NUM_SLAVES-1:0]    s_ack_i,
    input  logic [NUM_SLAVES-1:0]    s_int_i,
    output logic [NUM_SLAVES-1:0]    int_src_o
);

    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    we_q, we_d;
    logic [15:0]             cnt_q, cnt_d;
    logic                    ack_q, ack_d;
    logic                    err_q, err_d;
    logic [31:0]             dat_q, dat_d;
    logic                    int_q;
    logic [NUM_SLAVES-1:0]   int_src_q;

    logic [31:0]             sel_ext;
    logic                    mapped;
    logic                    sel_ack;
    logic [31:0]             sel_dat;
    logic [NUM_SLAVES-1:0]   sel_onehot;

    // Slave-select field decode; anything at or above NUM_SLAVES is unmapped.
    always_comb begin
        sel_ext = 32'(m_adr_i[SEL_MSB:SEL_LSB]);
        mapped  = (sel_ext < 32'(NUM_SLAVES));
    end

    // Only the latched slave's ack and data are ever looked at.
    always_comb begin
        sel_ack = s_ack_i[idx_q];
        sel_dat = s_dat_i[32*idx_q +: 32];
    end

    always_comb begin
        sel_onehot = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            sel_onehot[i] = (state_q == ACTIVE) && (idx_q == IDX_W'(i));
        end
    end

    assign s_cyc_o   = sel_onehot;
    assign s_stb_o   = sel_onehot;
    assign s_we_o    = sel_onehot & {NUM_SLAVES{we_q}};
    assign s_adr_o   = m_adr_i;
    assign s_dat_o   = m_dat_i;

    assign m_dat_o   = dat_q;
    assign m_ack_o   = ack_q;
    assign m_err_o   = err_q;
    assign m_int_o   = int_q;
    assign int_src_o = int_src_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        we_d    = we_q;
        cnt_d   = cnt_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        dat_d   = dat_q;
        unique case (state_q)
            IDLE: begin
                if (m_cyc_i && m_stb_i) begin
                    if (mapped) begin
                        idx_d   = sel_ext[IDX_W-1:0];
                        we_d    = m_we_i;
                        cnt_d   = 16'd0;
                        state_d = ACTIVE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            ACTIVE: begin
                // Master abandoning the cycle beats everything; an ack beats the timeout.
                if (!m_cyc_i) begin
                    state_d = IDLE;
                end else if (sel_ack) begin
                    ack_d   = 1'b1;
                    dat_d   = sel_dat;
                    state_d = DONE;
                end else if (cnt_q + 16'd1 == 16'(TIMEOUT)) begin
                    cnt_d   = cnt_q + 16'd1;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + 16'd1;
                end
            end
            DONE: begin
                if (!m_stb_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            we_q      <= 1'b0;
            cnt_q     <= 16'd0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            dat_q     <= 32'd0;
            int_q     <= 1'b0;
            int_src_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            we_q      <= we_d;
            cnt_q     <= cnt_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            dat_q     <= dat_d;
            int_q     <= |s_int_i;
            int_src_q <= s_int_i;
        end
    end

endmodule

// File: tb/tb_wishbone_arbitrated_interconnect.sv
// Directed bench for wishbone_arbitrated_interconnect (4 slaves, TIMEOUT=8).
module tb_wishbone_arbitrated_interconnect;

    logic         clk = 1'b0;
    logic         rst;
    logic         m_we_i, m_cyc_i, m_stb_i;
    logic [31:0]  m_adr_i, m_dat_i;
    logic [31:0]  m_dat_o;
    logic         m_ack_o, m_err_o, m_int_o;
    logic [3:0]   s_we_o, s_cyc_o, s_stb_o;
    logic [31:0]  s_adr_o, s_dat_o;
    logic [127:0] s_dat_i;
    logic [3:0]   s_ack_i, s_int_i;
    logic [3:0]   int_src_o;

    int total = 0;
    int bad   = 0;

    wishbone_arbitrated_interconnect #(
        .NUM_SLAVES(4), .SEL_MSB(31), .SEL_LSB(24), .TIMEOUT(8)
    ) dut (
        .clk(clk), .rst(rst),
        .m_we_i(m_we_i), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_int_o(m_int_o),
        .s_we_o(s_we_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_int_i(s_int_i),
        .int_src_o(int_src_o)
    );

    always #5 clk = ~clk;

    // ack and err must never coincide
    always @(negedge clk) begin
        if (m_ack_o && m_err_o) begin
            bad++;
            $display("FAIL ack_err_overlap: ack=%0b err=%0b required not both 1", m_ack_o, m_err_o);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_master();
        m_cyc_i = 1'b0; m_stb_i = 1'b0; m_we_i = 1'b0;
        m_adr_i = 32'd0; m_dat_i = 32'd0; s_ack_i = 4'b0;
    endtask

    task automatic test_reset();
        idle_master();
        s_int_i = 4'b0;
        s_dat_i = {32'h33333333, 32'hDEADBEEF, 32'h22222222, 32'h11111111};
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        total++; if (m_ack_o !== 1'b0) begin bad++; $display("FAIL rst_ack: got %0b want 0", m_ack_o); end
        total++; if (m_err_o !== 1'b0) begin bad++; $display("FAIL rst_err: got %0b want 0", m_err_o); end
        total++; if (m_dat_o !== 32'd0) begin bad++; $display("FAIL rst_dat: got %h want 0", m_dat_o); end
        total++; if ({s_cyc_o, s_stb_o, s_we_o} !== 12'd0) begin bad++; $display("FAIL rst_slave_ctl: got %h want 0", {s_cyc_o, s_stb_o, s_we_o}); end
        total++; if ({m_int_o, int_src_o} !== 5'd0) begin bad++; $display("FAIL rst_int: got %h want 0", {m_int_o, int_src_o}); end
    endtask

    task automatic test_read_slave2();
        m_adr_i = 32'h0200_0010; m_cyc_i = 1'b1; m_stb_i = 1'b1; m_we_i = 1'b0;
        tick();
        total++; if (s_stb_o !== 4'b0100) begin bad++; $display("FAIL rd_stb: got %b want 0100", s_stb_o); end
        total++; if (s_cyc_o !== 4'b0100) begin bad++; $display("FAIL rd_cyc: got %b want 0100", s_cyc_o); end
        total++; if (s_we_o !== 4'b0000) begin bad++; $display("FAIL rd_we: got %b want 0000", s_we_o); end
        total++; if (s_adr_o !== 32'h0200_0010) begin bad++; $display("FAIL rd_adr: got %h want 02000010", s_adr_o); end
        tick(); tick();
        total++; if (s_stb_o !== 4'b0100 || m_ack_o !== 1'b0) begin bad++; $display("FAIL rd_wait: stb=%b ack=%0b want 0100/0", s_stb_o, m_ack_o); end
        s_ack_i = 4'b0100;
        tick();
        s_ack_i = 4'b0000;
        total++; if (m_ack_o !== 1'b1) begin bad++; $display("FAIL rd_ack: got %0b want 1", m_ack_o); end
        total++; if (m_dat_o !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_dat: got %h want deadbeef", m_dat_o); end
        total++; if (s_stb_o !== 4'b0000) begin bad++; $display("FAIL rd_stb_drop: got %b want 0000", s_stb_o); end
        tick();
        total++; if (m_ack_o !== 1'b0) begin bad++; $display("FAIL rd_ack_one: got %0b want 0", m_ack_o); end
        total++; if (m_dat_o !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_dat_hold: got %h want deadbeef", m_dat_o); end
        idle_master();
        tick();
    endtask

    task automatic test_unmapped();
        m_adr_i = 32'h0700_0000; m_cyc_i = 1'b1; m_stb_i = 1'b1;
        tick();
        total++; if (m_err_o !== 1'b1) begin bad++; $display("FAIL um_err: got %0b want 1", m_err_o); end
        total++; if (s_stb_o !== 4'b0000 || m_ack_o !== 1'b0) begin bad++; $display("FAIL um_quiet: stb=%b ack=%0b want 0000/0", s_stb_o, m_ack_o); end
        tick();
        total++; if (m_err_o !== 1'b0 || s_stb_o !== 4'b0000) begin bad++; $display("FAIL um_err_one: err=%0b stb=%b want 0/0000", m_err_o, s_stb_o); end
        idle_master();
        tick();
    endtask

    task automatic test_timeout(input logic ack_at_limit);
        m_adr_i = 32'h0100_0000; m_cyc_i = 1'b1; m_stb_i = 1'b1;
        tick();
        for (int c = 2; c <= 8; c++) begin
            tick();
        end
        total++; if (s_stb_o !== 4'b0010 || m_err_o !== 1'b0) begin bad++; $display("FAIL to_cycle8: stb=%b err=%0b want 0010/0", s_stb_o, m_err_o); end
        if (ack_at_limit) s_ack_i = 4'b0010;
        tick();
        s_ack_i = 4'b0000;
        if (ack_at_limit) begin
            total++; if (m_ack_o !== 1'b1 || m_err_o !== 1'b0) begin bad++; $display("FAIL to_ack_wins: ack=%0b err=%0b want 1/0", m_ack_o, m_err_o); end
            total++; if (m_dat_o !== 32'h22222222) begin bad++; $display("FAIL to_ack_dat: got %h want 22222222", m_dat_o); end
        end else begin
            total++; if (m_err_o !== 1'b1 || m_ack_o !== 1'b0) begin bad++; $display("FAIL to_err: err=%0b ack=%0b want 1/0", m_err_o, m_ack_o); end
        end
        total++; if (s_stb_o !== 4'b0000) begin bad++; $display("FAIL to_stb_drop: got %b want 0000", s_stb_o); end
        tick();
        total++; if (m_err_o !== 1'b0 || m_ack_o !== 1'b0 || s_stb_o !== 4'b0000) begin bad++; $display("FAIL to_done: err=%0b ack=%0b stb=%b want 0/0/0000", m_err_o, m_ack_o, s_stb_o); end
        idle_master();
        tick();
    endtask

    task automatic test_back_to_back();
        int acks;
        m_adr_i = 32'h0000_0040; m_cyc_i = 1'b1; m_stb_i = 1'b1; m_we_i = 1'b1; m_dat_i = 32'hCAFE0001;
        tick();
        total++; if (s_we_o !== 4'b0001 || s_stb_o !== 4'b0001) begin bad++; $display("FAIL wr_ctl: we=%b stb=%b want 0001/0001", s_we_o, s_stb_o); end
        total++; if (s_dat_o !== 32'hCAFE0001) begin bad++; $display("FAIL wr_dat_out: got %h want cafe0001", s_dat_o); end
        s_ack_i = 4'b0001;
        tick();
        s_ack_i = 4'b0000;
        acks = int'(m_ack_o);
        for (int c = 0; c < 10; c++) begin
            tick();
            acks += int'(m_ack_o);
            if (s_stb_o !== 4'b0000) acks += 100;
        end
        total++; if (acks !== 1) begin bad++; $display("FAIL held_stb_acks: got %0d want 1", acks); end
        m_stb_i = 1'b0;
        tick();
        m_stb_i = 1'b1;
        tick();
        total++; if (s_stb_o !== 4'b0001) begin bad++; $display("FAIL restart_stb: got %b want 0001", s_stb_o); end
        s_ack_i = 4'b0001;
        tick();
        s_ack_i = 4'b0000;
        total++; if (m_ack_o !== 1'b1 || m_dat_o !== 32'h11111111) begin bad++; $display("FAIL restart_ack: ack=%0b dat=%h want 1/11111111", m_ack_o, m_dat_o); end
        idle_master();
        tick();
    endtask

    task automatic test_stray_abort();
        m_adr_i = 32'h0000_0000; m_cyc_i = 1'b1; m_stb_i = 1'b1;
        tick();
        s_ack_i = 4'b1000;
        tick();
        s_ack_i = 4'b0000;
        total++; if (m_ack_o !== 1'b0 || s_stb_o !== 4'b0001) begin bad++; $display("FAIL stray_ack: ack=%0b stb=%b want 0/0001", m_ack_o, s_stb_o); end
        m_cyc_i = 1'b0; m_stb_i = 1'b0;
        tick();
        total++; if (m_ack_o !== 1'b0 || m_err_o !== 1'b0 || s_stb_o !== 4'b0000) begin bad++; $display("FAIL abort: ack=%0b err=%0b stb=%b want 0/0/0000", m_ack_o, m_err_o, s_stb_o); end
        m_cyc_i = 1'b1; m_stb_i = 1'b1;
        tick();
        total++; if (s_stb_o !== 4'b0001) begin bad++; $display("FAIL abort_idle: got %b want 0001", s_stb_o); end
        s_ack_i = 4'b0001;
        tick();
        s_ack_i = 4'b0000;
        idle_master();
        tick();
    endtask

    task automatic test_reset_mid_active_int();
        m_adr_i = 32'h0200_0000; m_cyc_i = 1'b1; m_stb_i = 1'b1;
        tick();
        total++; if (s_stb_o !== 4'b0100) begin bad++; $display("FAIL rma_active: got %b want 0100", s_stb_o); end
        rst = 1'b1; s_int_i = 4'b0100;
        idle_master();
        tick();
        rst = 1'b0;
        total++; if ({m_ack_o, m_err_o, s_stb_o, s_cyc_o} !== 10'd0 || m_dat_o !== 32'd0) begin bad++; $display("FAIL rma_outputs: ctl=%h dat=%h want 0/0", {m_ack_o, m_err_o, s_stb_o, s_cyc_o}, m_dat_o); end
        total++; if (int_src_o !== 4'b0000 || m_int_o !== 1'b0) begin bad++; $display("FAIL rma_int_rst: src=%b int=%0b want 0000/0", int_src_o, m_int_o); end
        tick();
        total++; if (int_src_o !== 4'b0100 || m_int_o !== 1'b1) begin bad++; $display("FAIL int_follow: src=%b int=%0b want 0100/1", int_src_o, m_int_o); end
        total++; if (m_ack_o !== 1'b0 || m_err_o !== 1'b0) begin bad++; $display("FAIL rma_no_pulse: ack=%0b err=%0b want 0/0", m_ack_o, m_err_o); end
        s_int_i = 4'b0000;
        tick();
        total++; if (int_src_o !== 4'b0000 || m_int_o !== 1'b0) begin bad++; $display("FAIL int_clear: src=%b int=%0b want 0000/0", int_src_o, m_int_o); end
    endtask

    initial begin
        test_reset();
        test_read_slave2();
        test_unmapped();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_back_to_back();
        test_stray_abort();
        test_reset_mid_active_int();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wishbone_arbitrated_interconnect.md
WISHBONE_ARBITRATED_INTERCONNECT -- requirements
Module: wishbone_arbitrated_interconnect

Interface
REQ-001 SHALL have parameter NUM_SLAVES, default 4, number of slave ports (legal 1..16).
REQ-002 SHALL have parameter SEL_MSB, default 31, top bit of the slave-select field in m_adr_i.
REQ-003 SHALL have parameter SEL_LSB, default 24, bottom bit of the slave-select field.
REQ-004 SHALL have parameter TIMEOUT, default 255, maximum ACTIVE cycles to wait for s_ack_i (legal 1..65535).
REQ-005 SHALL have clk  input  1  single clock, all logic on rising edge.
REQ-006 SHALL have rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have m_we_i, m_cyc_i, m_stb_i  input  1 each  master write enable, cycle and strobe.
REQ-008 SHALL have m_adr_i  input  32  master address; m_dat_i  input  32  master write data.
REQ-009 SHALL have m_dat_o  output  32  registered read data; m_ack_o  output  1  registered ack.
REQ-010 SHALL have m_err_o  output  1  registered error (unmapped or timeout); m_int_o  output  1  registered OR of slave interrupts.
REQ-011 SHALL have s_we_o, s_cyc_o, s_stb_o  output  NUM_SLAVES each  per-slave controls, bit i = slave i.
REQ-012 SHALL have s_adr_o  output  32, s_dat_o  output  32  broadcast address and write data (combinational from master).
REQ-013 SHALL have s_dat_i  input  32*NUM_SLAVES  slave i in bits [32*i+31:32*i]; s_ack_i, s_int_i  input  NUM_SLAVES.
REQ-014 SHALL have int_src_o  output  NUM_SLAVES  registered copy of s_int_i.

Function
REQ-015 SHALL decode idx = m_adr_i[SEL_MSB:SEL_LSB]; idx < NUM_SLAVES is mapped, otherwise unmapped.
REQ-016 SHALL implement FSM states IDLE, ACTIVE, DONE.
REQ-017 IDLE: on m_cyc_i & m_stb_i with mapped idx, SHALL latch idx and m_we_i, enter ACTIVE, assert s_cyc_o[idx]/s_stb_o[idx] from the next cycle.
REQ-018 IDLE: on m_cyc_i & m_stb_i with unmapped idx, SHALL pulse m_err_o for exactly one cycle on the next cycle and enter DONE; no slave strobed.
REQ-019 ACTIVE: only the latched slave SHALL see cyc/stb/we high; all other bits of s_cyc_o/s_stb_o/s_we_o SHALL be 0.
REQ-020 ACTIVE: on s_ack_i[idx], SHALL capture that slave's s_dat_i into m_dat_o, pulse m_ack_o for one cycle on the next cycle, drop slave cyc/stb on that same next cycle, enter DONE.
REQ-021 Acks from non-selected slaves SHALL be ignored in every state.
REQ-022 ACTIVE: timeout counter SHALL reset to 0 on ACTIVE entry, increment each ACTIVE cycle without ack; on reaching TIMEOUT SHALL pulse m_err_o one cycle, drop slave strobes, enter DONE.
REQ-023 Ack arriving on the same cycle the counter reaches TIMEOUT SHALL win: m_ack_o, not m_err_o.
REQ-024 ACTIVE: if m_cyc_i drops, SHALL drop slave strobes next cycle, return to IDLE, assert neither m_ack_o nor m_err_o.
REQ-025 DONE: SHALL wait until m_stb_i is 0, then enter IDLE; a held strobe SHALL never start a second transaction.
REQ-026 Latency: mapped request sampled cycle 0 -> slave strobe cycle 1 -> slave ack cycle k -> m_ack_o cycle k+1; unmapped -> m_err_o cycle 1.
REQ-027 m_dat_o SHALL hold its last captured value until the next successful read/write ack.
REQ-028 m_ack_o and m_err_o SHALL never be high in the same cycle.
REQ-029 m_int_o SHALL equal |s_int_i and int_src_o SHALL equal s_int_i, both delayed one cycle, independent of FSM state.

Reset
REQ-030 On rst high at a clock edge SHALL force FSM to IDLE, counter 0, m_ack_o/m_err_o/m_int_o 0, m_dat_o 0, s_cyc_o/s_stb_o/s_we_o all 0, int_src_o 0.
REQ-031 Reset asserted mid-ACTIVE SHALL abort the transaction with no ack or error pulse after reset deasserts.

Verification
REQ-032 Read slave 2: m_adr_i=0x0200_0010, cyc/stb=1, slave 2 acks 3 cycles later with 0xDEADBEEF -> only s_stb_o[2] high, m_ack_o one cycle, m_dat_o=0xDEADBEEF.
REQ-033 Unmapped: m_adr_i=0x0700_0000, NUM_SLAVES=4 -> m_err_o high one cycle at cycle 1, s_stb_o=0, m_ack_o=0.
REQ-034 Timeout: TIMEOUT=8, slave 1 never acks -> m_err_o after 8 ACTIVE cycles, s_stb_o[1] drops, FSM to DONE.
REQ-035 Held strobe: master keeps stb=1 for 10 cycles after ack -> exactly one m_ack_o pulse; new transaction only after stb low then high.
REQ-036 Stray ack / abort: slave 3 acks while slave 0 active -> ignored; then m_cyc_i drops -> no ack/err, IDLE next cycle.
REQ-037 Reset mid-ACTIVE and interrupts: rst during ACTIVE -> all outputs 0; s_int_i=4'b0100 -> int_src_o=4'b0100, m_int_o=1 one cycle later.
